prog_delay_line: RTL and testbench



---
 rtl/prog_delay_line_pkg.sv | 16 +
 rtl/prog_delay_line_mem.sv | 50 +++++
 rtl/prog_delay_line.sv | 102 ++++++++++
 tb/tb_prog_delay_line.sv | 139 +++++++++++++
 4 files changed

// File: rtl/prog_delay_line_pkg.sv
// Shared types and helpers for the programmable delay line.
package prog_delay_pkg;

    localparam int DEF_DATA_W    = 24;
    localparam int DEF_MAX_DELAY = 16;

    typedef enum logic {
        REFILL = 1'b0,
        RUN    = 1'b1
    } state_t;

    function automatic int unsigned clamp_delay(input int unsigned sel, input int unsigned max_d);
        return (sel > max_d) ? max_d : sel;
    endfunction

endpackage

// File: rtl/prog_delay_line_mem.sv
// Ring storage for the delay line: synchronous write, asynchronous read.
// Define PROG_DELAY_DATA_RESET_EN to clear the data entries on reset as well.
module dl_ring_mem #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvld,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvld
);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  vld_mem;

    // Valid bits are always cleared so no pre-reset sample can resurface.
    always_ff @(posedge clk) begin
        if (rst)
            vld_mem <= '0;
        else if (we)
            vld_mem[waddr] <= wvld;
    end

`ifdef PROG_DELAY_DATA_RESET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                data_mem[i] <= '0;
        end else if (we) begin
            data_mem[waddr] <= wdata;
        end
    end
`else
    // No reset here so the array can map onto shift/distributed RAM.
    always_ff @(posedge clk) begin
        if (we)
            data_mem[waddr] <= wdata;
    end
`endif

    assign rdata = data_mem[raddr];
    assign rvld  = vld_mem[raddr];

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line with clock enable, valid tracking and refill blanking.
// Optional macro PROG_DELAY_DATA_RESET_EN (in dl_ring_mem) also clears stored data on reset.
module prog_delay_line
    import prog_delay_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int MAX_DELAY = DEF_MAX_DELAY,
    localparam int DELAY_W   = $clog2(MAX_DELAY + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [DELAY_W-1:0] delay_sel,
    input  logic [DATA_W-1:0]  din,
    input  logic               din_valid,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic               busy,
    output logic               delay_err
);

    localparam int          AW    = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam logic [31:0] MAX_U = 32'(MAX_DELAY);

    state_t             state, state_nxt;
    logic [AW-1:0]      wptr, rptr;
    logic [DELAY_W-1:0] delay_q, delay_c, fill_cnt, fill_nxt;
    logic [31:0]        sel_ext, raddr_full;
    logic               chg;
    logic [DATA_W-1:0]  mem_data;
    logic               mem_vld;

    assign sel_ext = 32'(delay_sel);
    assign delay_c = DELAY_W'(clamp_delay(sel_ext, MAX_U));
    assign chg     = (delay_c != delay_q);

    always_ff @(posedge clk) begin
        if (rst)
            wptr <= '0;
        else if (ce)
            wptr <= (wptr == AW'(MAX_DELAY - 1)) ? '0 : wptr + 1'b1;
    end

    // delay_q == MAX_DELAY lands on wptr itself: the oldest entry, read before its overwrite.
    assign raddr_full = 32'(wptr) + MAX_U - 32'(delay_q);
    assign rptr       = (raddr_full >= MAX_U) ? AW'(raddr_full - MAX_U) : AW'(raddr_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= REFILL;
            fill_cnt  <= '0;
            delay_q   <= '0;
            delay_err <= 1'b0;
        end else begin
            delay_q   <= delay_c;
            delay_err <= (sel_ext > MAX_U);
            if (chg) begin
                state    <= REFILL;
                fill_cnt <= '0;
            end else begin
                state    <= state_nxt;
                fill_cnt <= fill_nxt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_cnt;
        case (state)
            REFILL: begin
                if (fill_cnt >= delay_q)
                    state_nxt = RUN;
                else if (ce)
                    fill_nxt = fill_cnt + 1'b1;
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = REFILL;
        endcase
    end

    dl_ring_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_DELAY),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (ce),
        .waddr (wptr),
        .wdata (din),
        .wvld  (din_valid),
        .raddr (rptr),
        .rdata (mem_data),
        .rvld  (mem_vld)
    );

    assign dout       = (delay_q == '0) ? din : mem_data;
    assign dout_valid = (state == RUN) & ((delay_q == '0) ? din_valid : mem_vld);
    assign busy       = (state == REFILL);

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line: stimulus pushes expected outputs, a negedge monitor compares.
module tb_prog_delay_line;

    localparam int DW      = 24;
    localparam int MAXD    = 16;
    localparam int DELAY_W = $clog2(MAXD + 1);
`ifdef PROG_DELAY_DATA_RESET_EN
    localparam bit DRST = 1'b1;
`else
    localparam bit DRST = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst, ce, din_valid;
    logic [DELAY_W-1:0] delay_sel;
    logic [DW-1:0]      din, dout;
    logic               dout_valid, busy, delay_err;

    typedef struct packed {
        logic          chk;
        logic          v;
        logic          cd;
        logic [DW-1:0] d;
        logic          b;
        logic          e;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   ramp     = 0;

    prog_delay_line #(.DATA_W(DW), .MAX_DELAY(MAXD)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .delay_sel  (delay_sel),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .delay_err  (delay_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            if (x.chk) begin
                cmp("dout_valid", 32'(dout_valid), 32'(x.v));
                cmp("busy", 32'(busy), 32'(x.b));
                cmp("delay_err", 32'(delay_err), 32'(x.e));
                if (x.cd) cmp("dout", 32'(dout), 32'(x.d));
            end
        end
    end

    // One clk of stimulus; din is the running ramp, which advances only on ce-high cycles.
    task automatic step(input bit r, input int sel, input bit c, input bit dv, input bit chk,
                        input bit v, input bit cd, input logic [DW-1:0] dx, input bit b, input bit e);
        rst       = r;
        delay_sel = DELAY_W'(sel);
        ce        = c;
        din       = DW'(ramp);
        din_valid = dv;
        sb.push_back('{chk: chk, v: v, cd: cd, d: dx, b: b, e: e});
        @(posedge clk);
        #1;
        if (c) ramp++;
    endtask

    // Present a new delay: change cycle keeps the old behaviour, d+1 blank cycles, then steady run.
    task automatic phase(input int sel, input int dold, input bit vchg, input int d,
                         input int nrun, input bit echg, input bit e);
        step(0, sel, 1, 1, 1, vchg, vchg, DW'(ramp - dold), !vchg, echg);
        repeat (d + 1) step(0, sel, 1, 1, 1, 0, 0, '0, 1, e);
        repeat (nrun) step(0, sel, 1, 1, 1, 1, 1, DW'(ramp - d), 0, e);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; din = '0; din_valid = 1'b0; delay_sel = '0;
        @(posedge clk);
        #1;

        // Reset, then delay 4 on a continuous ramp.
        step(1, 4, 1, 0, 0, 0, 0, '0, 1, 0);
        step(1, 4, 1, 0, 1, 0, 0, '0, 1, 0);
        phase(4, 0, 0, 4, 12, 0, 0);

        // 4 -> 2 mid-stream.
        phase(2, 4, 1, 2, 8, 0, 0);

        // Bypass: one blank clk, then dout/dout_valid follow din/din_valid.
        step(0, 0, 1, 1, 1, 1, 1, DW'(ramp - 2), 0, 0);
        step(0, 0, 1, 1, 1, 0, 0, '0, 1, 0);
        for (int k = 0; k < 8; k++)
            step(0, 0, 1, k[0], 1, k[0], 1, DW'(ramp), 0, 0);

        // Maximum depth, run long enough to wrap the ring several times.
        phase(16, 0, 1, 16, 36, 0, 0);

        // Out-of-range request clamps to 16: no refill, error flag one clk later.
        step(0, 20, 1, 1, 1, 1, 1, DW'(ramp - 16), 0, 0);
        repeat (8) step(0, 20, 1, 1, 1, 1, 1, DW'(ramp - 16), 0, 1);

        // Delay 3, then toggle ce: output only advances on ce-high cycles.
        phase(3, 16, 1, 3, 4, 1, 0);
        for (int k = 0; k < 12; k++)
            step(0, 3, !k[0], 1, 1, 1, 1, DW'(ramp - 3), 0, 0);

        // Reset mid-stream with valid input: everything in flight is discarded.
        step(1, 3, 1, 1, 1, 1, 1, DW'(ramp - 3), 0, 0);
        step(0, 3, 1, 1, 1, 0, 0, '0, 1, 0);
        repeat (2) step(0, 3, 1, 1, 1, 0, DRST, '0, 1, 0);
        repeat (2) step(0, 3, 1, 1, 1, 0, 0, '0, 1, 0);
        repeat (6) step(0, 3, 1, 1, 1, 1, 1, DW'(ramp - 3), 0, 0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain remaining=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
